// File: rtl/nav_trig_scheduler.sv
// Round-robin scheduler sharing one fixed-latency sine unit between NUM_REQ navigation requesters.
// Optional quadrant folding with result sign restore: define TRIG_QUADRANT_FOLD_EN.
module nav_trig_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ANG_W   = 16,
   parameter int RES_W   = 16,
   parameter int SIN_LAT = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       req_cos,
   input  logic [NUM_REQ*ANG_W-1:0] req_angle,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [ANG_W-1:0]         trig_x,
   output logic                     trig_start,
   input  logic [RES_W-1:0]         trig_theta,
   output logic                     resp_valid,
   output logic [2:0]               resp_id,
   output logic [RES_W-1:0]         resp_data,
   output logic                     busy
);

   // Handshake: a requester holds req (with its angle/op stable) until it sees its gnt bit;
   // the angle is captured on the edge that raises gnt, so req may drop while gnt is high.
   // A requester that drops req before its grant is simply never served.

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [ANG_W-1:0] QUARTER = {2'b01, {(ANG_W-2){1'b0}}};

   logic [1:0]         state;
   logic [2:0]         ptr;
   logic [2:0]         cap_id;
   logic [ANG_W-1:0]   cap_angle;
   logic               cap_cos;
   logic [3:0]         cnt;

   logic [NUM_REQ-1:0] req_rot;
   logic [2:0]         pick_off;
   logic [3:0]         pick_sum;
   logic [2:0]         pick_idx;
   logic [ANG_W-1:0]   pick_angle;
   logic               pick_cos;
   logic [ANG_W-1:0]   eff_angle;
   logic [ANG_W-1:0]   issue_x;
   logic [RES_W-1:0]   result;

   assign busy = (state != S_IDLE);

   // Rotate so the pointer sits at bit 0; the lowest set bit is the next in round-robin order.
   assign req_rot  = NUM_REQ'({req, req} >> ptr);
   assign pick_sum = {1'b0, ptr} + {1'b0, pick_off};
   assign pick_idx = (pick_sum >= 4'(NUM_REQ)) ? 3'(pick_sum - 4'(NUM_REQ)) : pick_sum[2:0];

   always_comb begin
      pick_off = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (req_rot[i]) pick_off = 3'(i);
      end
   end

   always_comb begin
      pick_angle = '0;
      pick_cos   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == 3'(i)) begin
            pick_angle = req_angle[i*ANG_W +: ANG_W];
            pick_cos   = req_cos[i];
         end
      end
   end

   assign eff_angle = cap_angle + (cap_cos ? QUARTER : '0);

`ifdef TRIG_QUADRANT_FOLD_EN
   localparam logic [ANG_W-1:0] HALF    = {2'b10, {(ANG_W-2){1'b0}}};
   localparam logic [RES_W-1:0] RES_MIN = {1'b1, {(RES_W-1){1'b0}}};
   localparam logic [RES_W-1:0] RES_MAX = {1'b0, {(RES_W-1){1'b1}}};

   logic [1:0] quad;
   logic       sign_q;

   assign quad = eff_angle[ANG_W-1 -: 2];

   // Map every quadrant onto [0, quarter]; the lower half-circle carries a negative sine.
   always_comb begin
      issue_x = eff_angle;
      case (quad)
         2'd1:    issue_x = HALF - eff_angle;
         2'd2:    issue_x = eff_angle - HALF;
         2'd3:    issue_x = '0 - eff_angle;
         default: issue_x = eff_angle;
      endcase
   end

   assign result = !sign_q ? trig_theta :
                   (trig_theta == RES_MIN) ? RES_MAX : (RES_W'(0) - trig_theta);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q <= 1'b0;
      end else if (state == S_ISSUE) begin
         sign_q <= quad[1];
      end
   end
`else
   assign issue_x = eff_angle;
   assign result  = trig_theta;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ptr        <= '0;
         cap_id     <= '0;
         cap_angle  <= '0;
         cap_cos    <= 1'b0;
         cnt        <= '0;
         gnt        <= '0;
         trig_x     <= '0;
         trig_start <= 1'b0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_data  <= '0;
      end else begin
         gnt        <= '0;
         trig_start <= 1'b0;
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                  cap_angle <= pick_angle;
                  cap_cos   <= pick_cos;
                  cap_id    <= pick_idx;
                  ptr       <= (pick_idx == 3'(NUM_REQ-1)) ? 3'd0 : pick_idx + 3'd1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               trig_x     <= issue_x;
               trig_start <= 1'b1;
               cnt        <= 4'(SIN_LAT);
               state      <= S_WAIT;
            end
            S_WAIT: begin
               // cnt is SIN_LAT on the trig_start cycle, so RESP lines up with trig_theta valid.
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) state <= S_RESP;
            end
            default: begin
               resp_data  <= result;
               resp_id    <= cap_id;
               resp_valid <= 1'b1;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nav_trig_scheduler.sv
// Directed bench for nav_trig_scheduler with a fixed-latency sine-unit model.
// Expected values switch when TRIG_QUADRANT_FOLD_EN is defined.
module tb_nav_trig_scheduler;

   localparam int NUM_REQ = 4;
   localparam int ANG_W   = 16;
   localparam int RES_W   = 16;
   localparam int SIN_LAT = 3;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ-1:0]       req_cos;
   logic [ANG_W-1:0]         ang [NUM_REQ];
   logic [NUM_REQ*ANG_W-1:0] req_angle;
   logic [NUM_REQ-1:0]       gnt;
   logic [ANG_W-1:0]         trig_x;
   logic                     trig_start;
   logic [RES_W-1:0]         trig_theta;
   logic                     resp_valid;
   logic [2:0]               resp_id;
   logic [RES_W-1:0]         resp_data;
   logic                     busy;

   int tests = 0;
   int fails = 0;

   assign req_angle = {ang[3], ang[2], ang[1], ang[0]};

   nav_trig_scheduler #(
      .NUM_REQ(NUM_REQ), .ANG_W(ANG_W), .RES_W(RES_W), .SIN_LAT(SIN_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_cos(req_cos), .req_angle(req_angle),
      .gnt(gnt), .trig_x(trig_x), .trig_start(trig_start), .trig_theta(trig_theta),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Sine-unit model: value valid only SIN_LAT cycles after trig_start, poison otherwise.
   function automatic logic [15:0] sine_model(input logic [15:0] x);
      if (x == 16'h4000) return 16'h7FFF;
      if (x == 16'h0123) return 16'h8000;
      return x ^ 16'h1234;
   endfunction

   logic [2:0]  vpipe;
   logic [15:0] d0, d1, d2;
   always @(posedge clk) begin
      vpipe <= {vpipe[1:0], trig_start};
      d0    <= sine_model(trig_x);
      d1    <= d0;
      d2    <= d1;
   end
   assign trig_theta = vpipe[2] ? d2 : 16'hDEAD;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait for a grant, then follow that transaction to its response.
   task automatic expect_txn(input string tag, input logic [3:0] eg, input logic [3:0] drop,
                             input logic [15:0] ex, input logic [2:0] eid,
                             input logic [15:0] ed, input int ewait);
      int n;
      int starts;
      logic [15:0] sx;
      n = 0;
      while (gnt === 4'b0 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, " gnt"}, 32'(gnt), 32'(eg));
      if (ewait > 0) chk({tag, " gnt_wait"}, n, ewait);
      req = req & ~drop;
      n = 0;
      starts = 0;
      sx = '0;
      do begin
         tick();
         n++;
         if (trig_start) begin
            starts++;
            sx = trig_x;
         end
      end while (!resp_valid && n < 40);
      chk({tag, " latency"}, n, SIN_LAT + 2);
      chk({tag, " starts"}, starts, 1);
      chk({tag, " trig_x"}, 32'(sx), 32'(ex));
      chk({tag, " resp_id"}, 32'(resp_id), 32'(eid));
      chk({tag, " resp_data"}, 32'(resp_data), 32'(ed));
      chk({tag, " x_hold"}, 32'(trig_x), 32'(ex));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gcount;
      int rcount;
      logic [2:0] rid;
      logic [15:0] fx [4];
      logic [15:0] fd [4];
      int order [6];

      fx = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
      fd = '{16'h1334, 16'h1034, 16'h1134, 16'h1634};

      // Reset with all requests pending
      rst_n   = 1'b0;
      req     = 4'b1111;
      req_cos = 4'b0000;
      ang[0] = 16'h1000; ang[1] = 16'h0000; ang[2] = 16'h0000; ang[3] = 16'h0000;
      tick(); tick(); tick();
      chk("rst gnt", 32'(gnt), 32'h0);
      chk("rst trig_start", 32'(trig_start), 32'h0);
      chk("rst resp_valid", 32'(resp_valid), 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst trig_x", 32'(trig_x), 32'h0);
      chk("rst resp_id", 32'(resp_id), 32'h0);
      chk("rst resp_data", 32'(resp_data), 32'h0);
      rst_n = 1'b1;
      expect_txn("post_rst", 4'b0001, 4'b1111, 16'h1000, 3'd0, 16'h0234, 1);

      // Single sin on requester 2
      ang[2] = 16'h4000;
      req = 4'b0100;
      expect_txn("single_sin", 4'b0100, 4'b0100, 16'h4000, 3'd2, 16'h7FFF, 0);

      // Cos with quarter-turn wrap on requester 1
      ang[1] = 16'hE000;
      req_cos = 4'b0010;
      req = 4'b0010;
      expect_txn("cos_wrap", 4'b0010, 4'b0010, 16'h2000, 3'd1, 16'h3234, 0);
      req_cos = 4'b0000;

      // Fairness: reset pointer, hold all four requests
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) ang[i] = fx[i];
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         expect_txn($sformatf("rr%0d", k), 4'(1 << (k % 4)), 4'b0000,
                    fx[k % 4], 3'(k % 4), fd[k % 4], 1);
      end
      expect_txn("rr8", 4'b0001, 4'b0000, fx[0], 3'd0, fd[0], 1);
      expect_txn("rr9", 4'b0010, 4'b0010, fx[1], 3'd1, fd[1], 1);
      order = '{2, 3, 0, 2, 0, 0};
      for (int k = 0; k < 4; k++) begin
         expect_txn($sformatf("rr_drop%0d", k), 4'(1 << order[k]), 4'b0000,
                    fx[order[k]], 3'(order[k]), fd[order[k]], 1);
      end
      req = 4'b0000;
      tick(); tick();

      // Reset one cycle after trig_start
      req = 4'b1000;
      gcount = 0;
      while (gnt === 4'b0 && gcount < 40) begin
         tick();
         gcount++;
      end
      chk("mid_rst gnt", 32'(gnt), 32'b1000);
      tick();
      chk("mid_rst start", 32'(trig_start), 32'h1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst busy", 32'(busy), 32'h0);
      req = 4'b0000;
      tick(); tick();
      rst_n = 1'b1;
      rcount = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (resp_valid) rcount++;
      end
      chk("mid_rst no_resp", rcount, 0);

      // Request raised and dropped while busy is never granted
      req = 4'b0100;
      gcount = 0;
      while (gnt === 4'b0 && gcount < 40) begin
         tick();
         gcount++;
      end
      chk("busy_req first_gnt", 32'(gnt), 32'b0100);
      gcount = 0;
      rcount = 0;
      rid = '0;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) req = 4'b0001;
         if (i == 3) req = 4'b0000;
         tick();
         if (gnt != 4'b0) gcount++;
         if (resp_valid) begin
            rcount++;
            rid = resp_id;
         end
      end
      chk("busy_req no_gnt", gcount, 0);
      chk("busy_req one_resp", rcount, 1);
      chk("busy_req resp_id", 32'(rid), 32'd2);

      // Lower half-circle angles
      ang[0] = 16'hC000;
      req = 4'b0001;
`ifdef TRIG_QUADRANT_FOLD_EN
      expect_txn("fold_c000", 4'b0001, 4'b0001, 16'h4000, 3'd0, 16'h8001, 0);
      ang[0] = 16'h8123;
      req = 4'b0001;
      expect_txn("fold_sat", 4'b0001, 4'b0001, 16'h0123, 3'd0, 16'h7FFF, 0);
`else
      expect_txn("nofold_c000", 4'b0001, 4'b0001, 16'hC000, 3'd0, 16'hD234, 0);
      ang[0] = 16'h8123;
      req = 4'b0001;
      expect_txn("nofold_8123", 4'b0001, 4'b0001, 16'h8123, 3'd0, 16'h9317, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nav_trig_scheduler.md
Name: nav_trig_scheduler

Overview:
- Shares one fixed-latency sine unit between NUM_REQ navigation requesters, e.g. heading, waypoint bearing and odometry.
- Arbitrates requests round-robin and converts cosine requests to sine by adding a quarter-turn to the angle.
- Sequences the unit through its latency and returns tagged results.
- Sits between the navigation datapath and the trig lookup.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ANG_W, 16, angle width; unsigned binary angle, full circle = 2^ANG_W.
- RES_W, 16, signed result width from the sine unit (Q1.15).
- SIN_LAT, 3, fixed sine-unit latency in cycles from trig_start to trig_theta valid (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request; level held until granted
- req_cos  in  NUM_REQ  per-requester op: 0 = sin, 1 = cos
- req_angle  in  NUM_REQ*ANG_W  packed angles; requester i occupies bits [i*ANG_W +: ANG_W]
- gnt  out  NUM_REQ  one-hot one-cycle pulse; request accepted, angle captured
- trig_x  out  ANG_W  angle driven to the sine unit
- trig_start  out  1  one-cycle start pulse to the sine unit
- trig_theta  in  RES_W  sine-unit result, valid exactly SIN_LAT cycles after trig_start
- resp_valid  out  1  one-cycle result strobe
- resp_id  out  3  index of the requester that owns resp_data
- resp_data  out  RES_W  signed result
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): every output is 0; state=IDLE; round-robin pointer=0; latency counter=0.
- IDLE:
  - When any req bit is high, grant the first requester at or after the pointer, searching upward with wrap-around.
  - Assert gnt for that requester for one cycle.
  - Capture its angle, op and index.
  - Set pointer = (index+1) mod NUM_REQ.
  - Go to ISSUE.
- ISSUE:
  - trig_x = captured angle, plus 2^(ANG_W-2) if op=cos; the add wraps modulo 2^ANG_W.
  - trig_start=1 for this cycle only; load counter=SIN_LAT; go to WAIT.
  - trig_x holds its value until the next ISSUE.
- WAIT:
  - Decrement the counter every cycle.
  - When the counter reaches 1, go to RESP.
- RESP:
  - Register trig_theta into resp_data; drive resp_id; pulse resp_valid for one cycle.
  - Go to IDLE.
- Timing:
  - gnt to resp_valid = SIN_LAT+2 cycles.
  - Throughput is one request per SIN_LAT+3 cycles.
  - No new grant is issued while busy.
- Requester deasserting req before grant: dropped; no response.
- req arriving while busy: no gnt pulse; the request is considered at the next IDLE.
- Single requester holding req continuously: served back-to-back.
- Round-robin fairness: with all NUM_REQ requesting, each is served once per NUM_REQ transactions.
- Reset mid-operation: in-flight transaction discarded; no resp_valid; sine-unit output ignored after reset.
- Unused resp_id upper bits are 0 when NUM_REQ<8.

Optional Feature:
- Macro: TRIG_QUADRANT_FOLD_EN.
- Defined:
  - The sine unit is assumed to cover only the first quadrant [0, 2^(ANG_W-2)].
  - In ISSUE, the effective angle a (after the cos offset) is folded using its top two bits q:
    - q=0: trig_x = a.
    - q=1: trig_x = 2^(ANG_W-1) - a.
    - q=2: trig_x = a - 2^(ANG_W-1).
    - q=3: trig_x = 2^ANG_W - a.
  - The sign flag is (q>=2). It is held through WAIT.
  - In RESP, resp_data = sign ? -trig_theta : trig_theta, two's complement.
  - The most negative value saturates to +max on negate.
- Undefined: trig_x = a unfolded; resp_data = trig_theta unchanged; no sign logic is synthesized.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 -> gnt, trig_start, resp_valid, busy all 0; release -> gnt=4'b0001 on the first edge.
- Single sin: req[2]=1, angle=16'h4000, cos=0, model returns 16'h7FFF -> trig_x=16'h4000, one trig_start pulse, resp_valid exactly 5 cycles after gnt, resp_id=2, resp_data=16'h7FFF.
- Cos wrap: req[1], cos=1, angle=16'hE000 -> trig_x=16'h2000 (no fold) -> resp_id=1.
- Fairness:
  - All four held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
  - Release req[1] mid-run -> order continues 2,3,0,2.
- Reset mid-WAIT: assert rst_n=0 one cycle after trig_start -> no resp_valid; busy=0 immediately.
- Fold (TRIG_QUADRANT_FOLD_EN), sin angle=16'hC000 -> trig_x=16'h4000; model returns 16'h7FFF -> resp_data=16'h8001.
